// File: rtl/seq_control.sv
// seq_control: timing-step sequencer and control-strobe decoder for a basic accumulator CPU.
// Ports:
//    clk, rst                    clock, synchronous active-high reset
//    ir[15:0]                    instruction register (I, opcode, address/register-ref bits)
//    ac_neg, ac_zero, e_in,      status flags used by skip instructions
//    dr_zero
//    sc[3:0]                     current timing step
//    alu_select[2:0], bus_sel    ALU operation and common-bus source
//    ld_*/inr_*/clr_*/cme/mem_wr one-cycle register/memory strobes
//    halted                      set by HLT, cleared only by rst
// Optional feature: define SEQ_INDIRECT_EN to enable the T3 indirect address fetch.
module seq_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic        ac_neg,
   input  logic        ac_zero,
   input  logic        e_in,
   input  logic        dr_zero,
   output logic [3:0]  sc,
   output logic [2:0]  alu_select,
   output logic [2:0]  bus_sel,
   output logic        ld_ar,
   output logic        ld_ir,
   output logic        ld_dr,
   output logic        inr_dr,
   output logic        inr_pc,
   output logic        ld_pc,
   output logic        ld_ac,
   output logic        clr_ac,
   output logic        inr_ac,
   output logic        ld_e,
   output logic        clr_e,
   output logic        cme,
   output logic        mem_wr,
   output logic        halted
);
   logic [3:0] sc_q, sc_d;
   logic       halted_q, halted_d;
   logic       i_q;
   logic [2:0] op_q;
   logic       clr_sc;
   always_comb begin
      {alu_select, bus_sel} = '0;
      {ld_ar, ld_ir, ld_dr, inr_dr, inr_pc, ld_pc, ld_ac, clr_ac, inr_ac, ld_e, clr_e, cme, mem_wr} = '0;
      clr_sc   = 1'b0;
      halted_d = halted_q;
      if (!halted_q) begin
         if (sc_q == 4'd0) begin
            bus_sel = 3'd2;
            ld_ar   = 1'b1;
         end else if (sc_q == 4'd1) begin
            bus_sel = 3'd7;
            ld_ir   = 1'b1;
            inr_pc  = 1'b1;
         end else if (sc_q == 4'd2) begin
            bus_sel = 3'd5;
            ld_ar   = 1'b1;
         end else if (sc_q == 4'd3) begin
            if (op_q == 3'd7) begin
               clr_sc = 1'b1;
               // Register-reference: only the highest set bit of ir[11:0] executes
               if (!i_q)
                  casez (ir[11:0])
                     12'b1???????????: clr_ac = 1'b1;
                     12'b01??????????: clr_e = 1'b1;
                     12'b001?????????: begin alu_select = 3'd4; ld_ac = 1'b1; end
                     12'b0001????????: cme = 1'b1;
                     12'b00001???????: begin alu_select = 3'd5; ld_ac = 1'b1; ld_e = 1'b1; end
                     12'b000001??????: begin alu_select = 3'd6; ld_ac = 1'b1; ld_e = 1'b1; end
                     12'b0000001?????: inr_ac = 1'b1;
                     12'b00000001????: inr_pc = !ac_neg;
                     12'b000000001???: inr_pc = ac_neg;
                     12'b0000000001??: inr_pc = ac_zero;
                     12'b00000000001?: inr_pc = !e_in;
                     12'b000000000001: halted_d = 1'b1;
                     default: ;
                  endcase
            end
`ifdef SEQ_INDIRECT_EN
            else if (i_q) begin
               bus_sel = 3'd7;
               ld_ar   = 1'b1;
            end
`endif
         end else if (sc_q == 4'd4) begin
            if (op_q <= 3'd2 || op_q == 3'd6) begin
               bus_sel = 3'd7;
               ld_dr   = 1'b1;
            end else if (op_q == 3'd3) begin
               bus_sel = 3'd4;
               mem_wr  = 1'b1;
               clr_sc  = 1'b1;
            end else if (op_q == 3'd4) begin
               bus_sel = 3'd1;
               ld_pc   = 1'b1;
               clr_sc  = 1'b1;
            end else if (op_q == 3'd5) begin
               bus_sel = 3'd2;
               mem_wr  = 1'b1;
            end
         end else if (sc_q == 4'd5) begin
            if (op_q <= 3'd2) begin
               alu_select = op_q == 3'd0 ? 3'd2 : op_q == 3'd1 ? 3'd1 : 3'd3;
               ld_ac      = 1'b1;
               ld_e       = op_q == 3'd1;
               clr_sc     = 1'b1;
            end else if (op_q == 3'd5) begin
               bus_sel = 3'd1;
               ld_pc   = 1'b1;
               inr_pc  = 1'b1;
               clr_sc  = 1'b1;
            end else if (op_q == 3'd6)
               inr_dr = 1'b1;
         end else if (sc_q == 4'd6 && op_q == 3'd6) begin
            bus_sel = 3'd3;
            mem_wr  = 1'b1;
            inr_pc  = dr_zero;
            clr_sc  = 1'b1;
         end
      end
      // Saturating at T6 keeps sc within 0..6 even for an unexpected opcode path
      sc_d = (halted_q || clr_sc || sc_q >= 4'd6) ? 4'd0 : sc_q + 4'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sc_q     <= 4'd0;
         halted_q <= 1'b0;
         i_q      <= 1'b0;
         op_q     <= 3'd0;
      end else begin
         sc_q     <= sc_d;
         halted_q <= halted_d;
         if (sc_q == 4'd2 && !halted_q) begin
            i_q  <= ir[15];
            op_q <= ir[14:12];
         end
      end
   end
   assign sc     = sc_q;
   assign halted = halted_q;
endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on rising clk edge.
REQ-003 SHALL have port ir, input, 16, instruction register contents: ir[15] = I, ir[14:12] = opcode, ir[11:0] = address or register-ref bits.
REQ-004 SHALL have inputs ac_neg (1, AC[15]), ac_zero (1, AC==0), e_in (1, E flop), dr_zero (1, DR==0).
REQ-005 SHALL have output sc, 4, current timing step T0..T15.
REQ-006 SHALL have output alu_select, 3, ALU opcode: 0 idle, 1 add, 2 and, 3 pass DR, 4 complement AC, 5 shift right through E, 6 shift left through E.
REQ-007 SHALL have output bus_sel, 3, common-bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 memory.
REQ-008 SHALL have 1-bit outputs ld_ar, ld_ir, ld_dr, inr_dr, inr_pc, ld_pc, ld_ac, clr_ac, inr_ac, ld_e, clr_e, cme, mem_wr, halted.

Function
REQ-009 SHALL drive all outputs combinationally from sc, latched I, decoded opcode D0..D7 and status inputs; every strobe is active for exactly one cycle.
REQ-010 SHALL increment sc each cycle and clear it to 0 on the cycle after any step marked "clear SC".
REQ-011 T0 SHALL assert bus_sel=2, ld_ar (AR<-PC).
REQ-012 T1 SHALL assert bus_sel=7, ld_ir, inr_pc (IR<-M[AR], PC++).
REQ-013 T2 SHALL assert bus_sel=5, ld_ar, and register I=ir[15] and opcode=ir[14:12] for T3..T6.
REQ-014 T3 with D7 and I=0 (register-ref) SHALL execute by priority: bit11 clr_ac; bit10 clr_e; bit9 alu_select=4, ld_ac; bit8 cme; bit7 alu_select=5, ld_ac, ld_e; bit6 alu_select=6, ld_ac, ld_e; bit5 inr_ac; bit4 inr_pc if !ac_neg; bit3 inr_pc if ac_neg; bit2 inr_pc if ac_zero; bit1 inr_pc if !e_in; bit0 set halted; then clear SC.
REQ-015 When more than one bit of ir[11:0] is set, only the highest set bit SHALL execute.
REQ-016 T3 with D7 and I=1 (I/O) SHALL perform no transfer and clear SC.
REQ-017 T3 with !D7 and I=1 SHALL assert bus_sel=7, ld_ar (indirect); with I=0 no action.
REQ-018 AND/ADD/LDA (D0/D1/D2): T4 bus_sel=7, ld_dr; T5 ld_ac with alu_select 2/1/3, ld_e additionally for ADD (E<-ALU carry); clear SC.
REQ-019 STA: T4 bus_sel=4, mem_wr; clear SC. BUN: T4 bus_sel=1, ld_pc; clear SC.
REQ-020 BSA: T4 bus_sel=2, mem_wr, ld_ar is not asserted but AR increment is signalled via inr_pc=0 and ld_ar=0; T5 bus_sel=1, ld_pc, inr_pc; clear SC.
REQ-021 ISZ: T4 bus_sel=7, ld_dr; T5 inr_dr; T6 bus_sel=3, mem_wr, inr_pc if dr_zero; clear SC.
REQ-022 While halted=1, sc SHALL stay 0 and all strobes SHALL be 0; only rst leaves halt.
REQ-023 sc SHALL never exceed 6; reaching 7 forces sc to 0 next cycle with no strobes.

Reset
REQ-024 rst SHALL set sc=0, halted=0, latched I=0, opcode=0 on the next rising edge, overriding any step in progress; strobes SHALL be those of T0 in the cycle after reset.

Configuration
REQ-025 Macro SEQ_INDIRECT_EN defined: REQ-017 indirect fetch is active.
REQ-026 SEQ_INDIRECT_EN undefined: I is ignored for memory-reference instructions, T3 performs no action, and I=1 with D7 is treated as I/O NOP per REQ-016.

Verification
REQ-027 ir=0x1234 (ADD direct) from reset -> T0 ld_ar/bus 2; T1 ld_ir/inr_pc; T2 ld_ar/bus 5; T4 ld_dr/bus 7; T5 alu_select=1, ld_ac, ld_e; sc=0 next cycle.
REQ-028 ir=0x7800|0x0001 (CLA+HLT bits) -> T3 clr_ac only, halted stays 0; then ir=0x7001 -> halted=1, sc frozen at 0 for 20 cycles, all strobes 0.
REQ-029 ir=0x6100 ISZ, dr_zero=1 at T6 -> T6 mem_wr, bus_sel=3, inr_pc=1; with dr_zero=0 -> inr_pc=0.
REQ-030 ir=0x8200 with SEQ_INDIRECT_EN -> T3 bus_sel=7, ld_ar=1; without -> T3 all strobes 0, T4 ld_dr (AND).
REQ-031 ir=0x7010 (SPA) with ac_neg=0 -> inr_pc=1 at T3; ac_neg=1 -> inr_pc=0.
REQ-032 rst asserted at T5 of ISZ -> no T6 strobes, sc=0 and T0 strobes on the following cycle.
